fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I 3-stage pipeline. Maintains the PC and issues word reads to instruction memory over a single-outstanding request/valid handshake. Holds fetched instructions in an IF/ID register with a one-entry skid buffer. Pre-decodes each instruction into the opcode-class flags and `fun3`/`fun7` fields that the control decoder consumes, and handles stall and redirect (taken branch, jal, jalr) from later stages.

---
 rtl/rv_fetch_pkg.sv | 42 ++++
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_predecode.sv | 39 +++
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package rv_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned FUN3_W = 3;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Pre-decoded control fields handed to the decoder.
    typedef struct packed {
        logic              r_type;
        logic              i_type;
        logic              load;
        logic              store;
        logic              branch;
        logic              jal;
        logic              jalr;
        logic              lui;
        logic              auipc;
        logic [FUN3_W-1:0] fun3;
        logic              fun7;
        logic              illegal;
    } predecode_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
interface fetch_unit_if;
    import rv_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_predecode.sv
// Combinational opcode-class / field extraction for one instruction word.
module fetch_predecode
    import rv_fetch_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output predecode_t      pd_c
);

    logic [OPC_W-1:0] opc;
    logic             unused_bits;

    assign opc         = instr[OPC_W-1:0];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Class flags are one-hot; fun7 only meaningful for R-type and srli/srai.
    always_comb begin
        pd_c      = '0;
        pd_c.fun3 = instr[14:12];
        case (opc)
            OPC_R: begin
                pd_c.r_type = 1'b1;
                pd_c.fun7   = instr[30];
            end
            OPC_I: begin
                pd_c.i_type = 1'b1;
                pd_c.fun7   = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
            end
            OPC_LOAD:   pd_c.load    = 1'b1;
            OPC_STORE:  pd_c.store   = 1'b1;
            OPC_BRANCH: pd_c.branch  = 1'b1;
            OPC_JAL:    pd_c.jal     = 1'b1;
            OPC_JALR:   pd_c.jalr    = 1'b1;
            OPC_LUI:    pd_c.lui     = 1'b1;
            OPC_AUIPC:  pd_c.auipc   = 1'b1;
            default:    pd_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, IF/ID register with one-entry skid, pre-decode.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_instr,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_pc_plus4,
    output logic              r_type,
    output logic              i_type,
    output logic              load,
    output logic              store,
    output logic              branch,
    output logic              jal,
    output logic              jalr,
    output logic              lui,
    output logic              auipc,
    output logic [FUN3_W-1:0] fun3,
    output logic              fun7,
    output logic              illegal
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            skid_valid_q;
    logic [XLEN-1:0] skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    predecode_t      if_pd_q;

    logic            consume;
    logic            issue;
    logic            load_resp;
    logic            load_skid;
    logic            cap_skid;
    logic            clear_if;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] load_pc;
    predecode_t      load_pd;

    // Next state and datapath controls; redirect overrides everything.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        load_resp = 1'b0;
        load_skid = 1'b0;
        cap_skid  = 1'b0;
        clear_if  = 1'b0;
        consume   = if_valid & ~stall;

        if (redirect_valid) begin
            // Any still-outstanding response must be dropped when it lands.
            state_d = (state_q != ST_IDLE && !imem.imem_valid) ? ST_DISCARD : ST_IDLE;
        end else begin
            if (skid_valid_q && (consume || !if_valid)) begin
                load_skid = 1'b1;
            end else if (consume) begin
                clear_if = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!skid_valid_q) begin
                        issue   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_valid) begin
                        if ((!if_valid || consume) && !skid_valid_q) begin
                            load_resp = 1'b1;
                            clear_if  = 1'b0;
                            issue     = 1'b1;
                            state_d   = ST_WAIT;
                        end else begin
                            cap_skid = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (imem.imem_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and request issue; imem_addr doubles as the pc of the outstanding response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= RESET_PC;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
        end else begin
            imem.imem_req <= issue;
            if (issue) begin
                imem.imem_addr <= pc_q;
            end
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~XLEN'(3);
            end else if (issue) begin
                pc_q <= pc_q + XLEN'(4);
            end
        end
    end

    // One-entry skid holding a response that arrived while IF/ID was stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            skid_valid_q <= 1'b0;
        end else if (cap_skid) begin
            skid_valid_q <= 1'b1;
            skid_instr_q <= imem.imem_rdata;
            skid_pc_q    <= imem.imem_addr;
        end else if (load_skid) begin
            skid_valid_q <= 1'b0;
        end
    end

    assign load_instr = load_skid ? skid_instr_q : imem.imem_rdata;
    assign load_pc    = load_skid ? skid_pc_q : imem.imem_addr;

    fetch_predecode u_predecode (
        .instr (load_instr),
        .pd_c  (load_pd)
    );

    // IF/ID register; pre-decode fields are zeroed whenever it holds a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= RESET_PC;
            if_pc_plus4 <= RESET_PC + XLEN'(4);
            if_pd_q     <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_pd_q  <= '0;
        end else if (load_skid || load_resp) begin
            if_valid    <= 1'b1;
            if_instr    <= load_instr;
            if_pc       <= load_pc;
            if_pc_plus4 <= load_pc + XLEN'(4);
            if_pd_q     <= load_pd;
        end else if (clear_if) begin
            if_valid <= 1'b0;
            if_pd_q  <= '0;
        end
    end

    assign r_type  = if_pd_q.r_type;
    assign i_type  = if_pd_q.i_type;
    assign load    = if_pd_q.load;
    assign store   = if_pd_q.store;
    assign branch  = if_pd_q.branch;
    assign jal     = if_pd_q.jal;
    assign jalr    = if_pd_q.jalr;
    assign lui     = if_pd_q.lui;
    assign auipc   = if_pd_q.auipc;
    assign fun3    = if_pd_q.fun3;
    assign fun7    = if_pd_q.fun7;
    assign illegal = if_pd_q.illegal;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory plus in-order delivery model.
module tb_fetch_unit;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        r_type, i_type, load, store, branch, jal, jalr, lui, auipc;
    logic [2:0]  fun3;
    logic        fun7, illegal;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .r_type         (r_type),
        .i_type         (i_type),
        .load           (load),
        .store          (store),
        .branch         (branch),
        .jal            (jal),
        .jalr           (jalr),
        .lui            (lui),
        .auipc          (auipc),
        .fun3           (fun3),
        .fun7           (fun7),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] prog [0:255];

    // stimulus knobs
    int          lat = 1;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          redir_mode = 0;     // 1: redirect next cycle, 2: redirect on next response
    logic [31:0] redir_target = 32'h0;
    bit          redir_fired = 1'b0;
    bit          stall_on_valid = 1'b0;
    bit          stall_fired = 1'b0;
    int          stall_force = 0;

    // memory model
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_dly = 0;

    // delivery model
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] next_req = 32'h0;
    int          delivered = 0;
    bit          hold = 1'b0;
    logic [31:0] hold_instr, hold_pc;
    bit          wrap_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {r,i,load,store,branch,jal,jalr,lui,auipc,fun3,fun7,illegal}.
    function automatic logic [13:0] ref_decode(input logic [31:0] w);
        logic [8:0] cls;
        logic       f7;
        cls = '0;
        f7  = 1'b0;
        case (w[6:0])
            7'b0110011: begin cls = 9'b100000000; f7 = w[30]; end
            7'b0010011: begin cls = 9'b010000000; f7 = (w[14:12] == 3'b101) && w[30]; end
            7'b0000011: cls = 9'b001000000;
            7'b0100011: cls = 9'b000100000;
            7'b1100011: cls = 9'b000010000;
            7'b1101111: cls = 9'b000001000;
            7'b1100111: cls = 9'b000000100;
            7'b0110111: cls = 9'b000000010;
            7'b0010111: cls = 9'b000000001;
            default:    cls = '0;
        endcase
        return {cls, w[14:12], f7, (cls == 9'd0)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(9))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b0010111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        #1;
        check("rst_req", imem_bus.imem_req, 1'b0);
        check("rst_addr", imem_bus.imem_addr, 32'h0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc", if_pc, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h4);
        check("rst_flags", {r_type, i_type, load, store, branch, jal, jalr, lui, auipc, fun3, fun7, illegal}, 14'h0);
        pend = 1'b0;
        hold = 1'b0;
        exp_pc = 32'h0;
        next_req = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One cycle: sample outputs, run memory model, drive inputs, score deliveries.
    task automatic tick();
        logic [13:0] dflags;
        logic [31:0] tgt, e4, word;
        bit          vnow, do_redir, consume;
        @(posedge clk);
        #1;
        dflags = {r_type, i_type, load, store, branch, jal, jalr, lui, auipc, fun3, fun7, illegal};
        if (!if_valid) check("bubble_flags", dflags, 14'h0);
        if (hold) begin
            check("hold_instr", if_instr, hold_instr);
            check("hold_pc", if_pc, hold_pc);
        end
        if (imem_bus.imem_req) begin
            check("req_addr", imem_bus.imem_addr, next_req);
            check("single_outstanding", pend, 1'b0);
            next_req  = next_req + 32'd4;
            pend      = 1'b1;
            pend_addr = imem_bus.imem_addr;
            pend_dly  = lat - 1;
        end
        vnow = pend && (pend_dly == 0);
        imem_bus.imem_valid = vnow;
        imem_bus.imem_rdata = vnow ? prog[pend_addr[9:2]] : $urandom;
        if (pend) begin
            if (pend_dly == 0) pend = 1'b0;
            else pend_dly--;
        end

        if (stall_force > 0) begin
            stall = 1'b1;
            stall_force--;
        end else if (stall_on_valid && vnow && if_valid) begin
            stall = 1'b1;
            stall_force = 2;
            stall_on_valid = 1'b0;
            stall_fired = 1'b1;
        end else begin
            stall = ($urandom_range(99) < stall_pct);
        end

        do_redir = 1'b0;
        tgt = $urandom;
        if (redir_mode == 1 || (redir_mode == 2 && vnow)) begin
            do_redir = 1'b1;
            tgt = redir_target;
            redir_mode = 0;
            redir_fired = 1'b1;
        end else if ($urandom_range(999) < redir_pct) begin
            do_redir = 1'b1;
        end
        redirect_valid = do_redir;
        redirect_pc = tgt;

        consume = if_valid && !stall;
        if (consume) begin
            word = prog[exp_pc[9:2]];
            e4 = exp_pc + 32'd4;
            check("out_pc", if_pc, exp_pc);
            check("out_instr", if_instr, word);
            check("out_pc4", if_pc_plus4, e4);
            check("out_flags", dflags, ref_decode(word));
            if (exp_pc == 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                check("wrap_pc4", if_pc_plus4, 32'h0);
                check("wrap_illegal", {illegal, r_type, i_type, load, store}, 5'b10000);
            end
            exp_pc = e4;
            delivered++;
        end
        hold = if_valid && stall && !do_redir;
        hold_instr = if_instr;
        hold_pc = if_pc;
        if (do_redir) begin
            exp_pc = tgt & ~32'd3;
            next_req = exp_pc;
        end
    endtask

    initial begin
        int  d0;
        bit  seen;
        for (int i = 0; i < 256; i++) prog[i] = rand_instr();
        prog[0]   = 32'h0050_0093;  // addi x1,x0,5
        prog[1]   = 32'h0020_81B3;  // add x3,x1,x2
        prog[2]   = 32'h0000_A203;  // lw x4,0(x1)
        prog[3]   = 32'h0040_A223;  // sw x4,4(x1)
        prog[4]   = 32'h0020_8463;  // beq x1,x2,8
        prog[5]   = 32'h0100_00EF;  // jal x1,16
        prog[6]   = 32'h0001_00E7;  // jalr x1,0(x2)
        prog[7]   = 32'h1234_52B7;  // lui x5,0x12345
        prog[8]   = 32'h0000_1317;  // auipc x6,1
        prog[9]   = 32'h4031_00B3;  // sub x1,x2,x3
        prog[10]  = 32'hC000_0093;  // addi x1,x0,-1024
        prog[11]  = 32'h4030_D093;  // srai x1,x1,3
        prog[12]  = 32'h0000_007F;  // illegal opcode
        prog[255] = 32'h0000_007F;  // at 0xFFFF_FFFC

        #2;
        do_reset();

        // back-to-back fetch, L=1, no stall
        d0 = delivered;
        repeat (20) tick();
        check("throughput", delivered - d0, 19);

        // 3-cycle stall as a response arrives
        stall_on_valid = 1'b1;
        for (int k = 0; k < 50 && !stall_fired; k++) tick();
        check("stall_trigger", stall_fired, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_noreq", imem_bus.imem_req, 1'b0);
        end
        repeat (10) tick();

        // redirect while a request is outstanding, L=3
        lat = 3;
        for (int k = 0; k < 50 && !(pend && pend_dly == 1); k++) tick();
        check("redir_trigger", pend && pend_dly == 1, 1'b1);
        redir_target = 32'h0000_0100;
        redir_mode = 1;
        tick();
        tick();
        check("redir_bubble", if_valid, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !imem_bus.imem_req; k++) begin
            if (if_valid) seen = 1'b1;
            tick();
        end
        check("redir_addr", imem_bus.imem_addr, 32'h0000_0100);
        check("redir_no_stale", seen, 1'b0);
        repeat (12) tick();

        // redirect coincident with a response, unaligned target
        lat = 2;
        redir_fired = 1'b0;
        redir_target = 32'h0000_0103;
        redir_mode = 2;
        for (int k = 0; k < 50 && !redir_fired; k++) tick();
        check("coinc_trigger", redir_fired, 1'b1);
        tick();
        check("coinc_bubble", if_valid, 1'b0);
        check("coinc_noreq", imem_bus.imem_req, 1'b0);
        tick();
        check("coinc_req", imem_bus.imem_req, 1'b1);
        check("coinc_addr", imem_bus.imem_addr, 32'h0000_0100);
        repeat (10) tick();

        // illegal opcode at the top of the address space
        lat = 1;
        redir_target = 32'hFFFF_FFFC;
        redir_mode = 1;
        repeat (10) tick();
        check("wrap_seen", wrap_seen, 1'b1);

        // reset asserted mid-WAIT
        lat = 3;
        for (int k = 0; k < 50 && !(pend && pend_dly == 1); k++) tick();
        check("rst_trigger", pend && pend_dly == 1, 1'b1);
        do_reset();
        d0 = delivered;
        repeat (12) tick();
        check("rst_refetch", (delivered - d0) > 0, 1'b1);

        // randomized traffic
        stall_pct = 30;
        redir_pct = 20;
        d0 = delivered;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) lat = $urandom_range(1, 4);
            tick();
        end
        check("random_progress", (delivered - d0) > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
